// File: rtl/hp_au_pkg.sv
// Shared definitions for the hybrid-precision arithmetic unit:
// nibble width, opcode constants and the sequencer state encoding.
package hp_au_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] OP_BIN_ADD = 2'b00;
  localparam logic [1:0] OP_BIN_SUB = 2'b01;
  localparam logic [1:0] OP_BCD_ADD = 2'b10;
  localparam logic [1:0] OP_ZERO    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hp_au_nibble_slice.sv
// One 4-bit digit of the HP-AU datapath: binary add, binary subtract
// (a + ~b + cin), BCD add with +6 correction, or forced zero.
module hp_au_nibble_slice
  import hp_au_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             digit_err
);

  logic [NIB_W:0] raw;
  logic [NIB_W:0] diff;
  logic [NIB_W:0] adj;

  // Digit arithmetic for the selected opcode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch behind.
    s         = '0;
    cout      = 1'b0;
    digit_err = 1'b0;
    raw  = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    diff = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
    adj  = raw + (NIB_W + 1)'(6);
    case (op)
      OP_BIN_ADD: begin
        s    = raw[NIB_W-1:0];
        cout = raw[NIB_W];
      end
      OP_BIN_SUB: begin
        s    = diff[NIB_W-1:0];
        cout = diff[NIB_W];
      end
      OP_BCD_ADD: begin
        // Out-of-range digits are not saturated; the same correction applies.
        if (raw > (NIB_W + 1)'(9)) begin
          s    = adj[NIB_W-1:0];
          cout = 1'b1;
        end else begin
          s    = raw[NIB_W-1:0];
        end
        digit_err = (a > NIB_W'(9)) || (b > NIB_W'(9));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hp_au_serial_ctrl.sv
// Multi-digit sequencer: accepts DIGITS-nibble operands over valid/ready,
// runs them one nibble per cycle through a shared slice, and presents the
// result, carry and BCD error flag until the consumer takes them.
module hp_au_serial_ctrl
  import hp_au_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIB_W*DIGITS-1:0] a,
  input  logic [NIB_W*DIGITS-1:0] b,
  input  logic [1:0]              sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIB_W*DIGITS-1:0] result,
  output logic                    carry,
  output logic                    bcd_err
);

  localparam int W     = NIB_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [1:0]       op_q;
  logic [W-1:0]     result_q;
  logic             carry_q;
  logic             err_q;

  logic             accept;
  logic             run;
  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             slice_err;

  assign accept = (state == ST_IDLE) && in_valid && in_ready_q;
  assign run    = (state == ST_RUN);

  // Operands are shifted right each digit, so the slice always sees nibble 0.
  hp_au_nibble_slice u_slice (
    .a         (a_q[NIB_W-1:0]),
    .b         (b_q[NIB_W-1:0]),
    .cin       (carry_q),
    .op        (op_q),
    .s         (slice_s),
    .cout      (slice_cout),
    .digit_err (slice_err)
  );

  // Sequencer FSM with registered handshake outputs and digit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_RUN;
            cnt        <= '0;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= ST_DONE;
            cnt         <= '0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch/shift, per-digit writeback, carry chain and sticky BCD error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ZERO;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      op_q     <= sel;
      result_q <= '0;
      carry_q  <= (sel == OP_BIN_SUB);
      err_q    <= 1'b0;
    end else if (run) begin
      a_q     <= a_q >> NIB_W;
      b_q     <= b_q >> NIB_W;
      carry_q <= slice_cout;
      err_q   <= err_q | slice_err;
      for (int i = 0; i < DIGITS; i++) begin
        if (cnt == CNT_W'(i)) result_q[i*NIB_W +: NIB_W] <= slice_s;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign bcd_err   = err_q;

endmodule

// File: tb/tb_hp_au_serial_ctrl.sv
// Self-checking bench for hp_au_serial_ctrl (DIGITS=4): directed vector
// table, reset/backpressure sequences, and random ops against a model.
module tb_hp_au_serial_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         bcd_err;

  int n_checks = 0;
  int n_errors = 0;

  hp_au_serial_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         e;
    int           hold;
    bit           poke;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  task automatic model(input logic [1:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output logic c, output logic e);
    int cy, raw, da, db;
    r = '0; c = 1'b0; e = 1'b0;
    case (s)
      2'b00: begin
        longint sum = longint'(av) + longint'(bv);
        r = sum[W-1:0];
        c = (sum >= (longint'(1) << W));
      end
      2'b01: begin
        r = av - bv;
        c = (av >= bv);
      end
      2'b10: begin
        cy = 0;
        for (int d = 0; d < DIGITS; d++) begin
          da  = int'((av >> (4 * d)) & 16'hF);
          db  = int'((bv >> (4 * d)) & 16'hF);
          if (da > 9 || db > 9) e = 1'b1;
          raw = da + db + cy;
          if (raw > 9) begin
            r[4*d +: 4] = 4'((raw + 6) % 16);
            cy = 1;
          end else begin
            r[4*d +: 4] = 4'(raw);
            cy = 0;
          end
        end
        c = (cy != 0);
      end
      default: ;
    endcase
  endtask

  // One complete operation: accept, latency, optional backpressure, handshake.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = v.a; b = v.b; sel = v.sel;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    for (int h = 0; h < v.hold; h++) begin
      if (v.poke) begin
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; sel = 2'b00;
      end
      @(posedge clk); @(negedge clk);
      check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " stall result"}, 32'(result), 32'(v.res));
    end
    out_ready = 1'b1;
    check({tag, " result"}, 32'(result), 32'(v.res));
    check({tag, " carry"}, 32'(carry), 32'(v.c));
    check({tag, " bcd_err"}, 32'(bcd_err), 32'(v.e));
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " idle result held"}, 32'(result), 32'(v.res));
    check({tag, " idle carry held"}, 32'(carry), 32'(v.c));
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [W-1:0] er;
    logic ec, ee;

    vecs.push_back('{2'b10, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b10, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b10, 16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b1, 0, 1'b0});
    vecs.push_back('{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b11, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b10, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 3, 1'b1});
    vecs.push_back('{2'b00, 16'h8421, 16'h1248, 16'h9669, 1'b0, 1'b0, 1, 1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sel = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry", 32'(carry), 32'd0);
    check("reset bcd_err", 32'(bcd_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset during the second RUN cycle aborts the operation.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sel = 2'b00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort carry", 32'(carry), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("abort hold out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort release in_ready", 32'(in_ready), 32'd1);
    check("abort release out_valid", 32'(out_valid), 32'd0);
    v = '{2'b10, 16'h0045, 16'h0055, 16'h0100, 1'b0, 1'b0, 0, 1'b0};
    run_op(v, "post-abort bcd");

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      v.sel = 2'($urandom);
      v.a   = W'($urandom);
      v.b   = W'($urandom);
      if (v.sel == 2'b10 && $urandom_range(3) != 0) begin
        for (int d = 0; d < DIGITS; d++) begin
          v.a[4*d +: 4] = 4'($urandom_range(9));
          v.b[4*d +: 4] = 4'($urandom_range(9));
        end
      end
      model(v.sel, v.a, v.b, er, ec, ee);
      v.res  = er; v.c = ec; v.e = ee;
      v.hold = $urandom_range(2);
      v.poke = 1'($urandom);
      run_op(v, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
